// File: rtl/byte_fetch_ctrl.sv
// rtl/byte_fetch_ctrl.sv - fetch a run of bytes from a sync-read byte memory onto a valid/ready stream
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   start, abort           transfer request (IDLE only) / cancel (any state)
//   base_addr, length      transfer descriptor, sampled with start
//   busy, done             activity flag / one-cycle completion pulse
//   mem_addr, mem_rd_en    read port to the byte memory (data one cycle later)
//   mem_rdata              read data from the byte memory
//   out_data, out_valid    stream byte and valid to the consumer
//   out_ready              stream ready from the consumer

module byte_fetch_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    // Highest address before wrap; equals the natural AW-bit rollover when
    // DEPTH is a power of two.
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr;
    logic [LW-1:0] rem;
    logic          handshake;

    // out_valid is a pure state decode, so the handshake only needs out_ready.
    assign handshake = (state == S_SEND) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (length != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: state_nxt = S_CAPT;
            S_CAPT: state_nxt = S_SEND;
            S_SEND: begin
                if (handshake) begin
                    // rem is never zero here in normal flow; treating <=1 as
                    // last keeps a corrupted count from looping forever.
                    state_nxt = (rem <= LW'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            rem      <= '0;
            out_data <= '0;
        end else if (abort) begin
            rem <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr <= base_addr;
                        rem  <= length;
                    end
                end
                S_CAPT: begin
                    out_data <= mem_rdata;
                end
                S_SEND: begin
                    if (handshake) begin
                        addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
                        if (rem != '0) begin
                            rem <= rem - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // All handshake/status outputs come straight from the state register.
    assign mem_addr  = addr;
    assign mem_rd_en = (state == S_READ);
    assign out_valid = (state == S_SEND);
    assign busy      = (state == S_READ) || (state == S_CAPT) || (state == S_SEND);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_byte_fetch_ctrl.sv
// tb/tb_byte_fetch_ctrl.sv - self-checking bench for byte_fetch_ctrl

module tb_byte_fetch_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;

    logic [7:0]    mem [DEPTH];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            stall_byte;
        int            stall_cycles;
        int            busy_start_at;
    } vec_t;

    vec_t vecs [7];

    byte_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // c counts negedges after the start edge E; c=1 shows the state entered at E.
    task automatic run_xfer(input vec_t v);
        int            nbytes;
        int            n_rd;
        int            prev_hs_c;
        int            done_c;
        int            stall_left;
        logic          prev_valid;
        logic [7:0]    held;
        logic [AW-1:0] exp_addr;
        nbytes = 0; n_rd = 0; prev_hs_c = 0; done_c = -1;
        stall_left = v.stall_cycles; prev_valid = 1'b0; held = 8'h00;
        exp_addr = v.base;
        @(negedge clk);
        base_addr = v.base; length = v.len; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        base_addr = v.base + 3'd3;
        length    = v.len + 4'd5;
        for (int c = 1; c <= 200; c++) begin
            start = 1'b0;
            if (c == 1) chk("busy_after_start", 32'(busy), 32'(v.len != 0));
            if (c == v.busy_start_at) start = 1'b1;
            if (mem_rd_en) begin
                n_rd++;
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("rd_en_cycle", c, (nbytes == 0) ? 1 : prev_hs_c + 1);
            end
            if (out_valid) begin
                if (!prev_valid) begin
                    chk("valid_cycle", c, (nbytes == 0) ? 3 : prev_hs_c + 3);
                    chk("out_data", 32'(out_data), 32'(mem[exp_addr]));
                    held = out_data;
                end
                if (nbytes == v.stall_byte && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    chk("stall_hold_data", 32'(out_data), 32'(held));
                    chk("stall_no_rd_en", 32'(mem_rd_en), 32'd0);
                end else begin
                    out_ready = 1'b1;
                    nbytes++;
                    exp_addr  = exp_addr + 1'b1;
                    prev_hs_c = c;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = out_valid;
            if (done) begin
                done_c = c;
                chk("done_cycle", c, (v.len == 0) ? 1 : prev_hs_c + 1);
                chk("bytes_at_done", nbytes, 32'(v.len));
                chk("reads_at_done", n_rd, 32'(v.len));
                start = 1'b1;   // start during DONE must be ignored
                break;
            end
            @(negedge clk);
        end
        if (done_c < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk_idle_outputs("after_done");
    endtask

    initial begin
        mem[0] = 8'h25; mem[1] = 8'h50; mem[2] = 8'h44; mem[3] = 8'h46;
        mem[4] = 8'h25; mem[5] = 8'h50; mem[6] = 8'h44; mem[7] = 8'h46;

        //          base  len    stall_byte stall_cyc busy_start_at
        vecs[0] = '{3'd0, 4'd4,  -1,        0,        0};
        vecs[1] = '{3'd6, 4'd4,  -1,        0,        4};
        vecs[2] = '{3'd0, 4'd10, -1,        0,        0};
        vecs[3] = '{3'd0, 4'd3,  1,         5,        0};
        vecs[4] = '{3'd3, 4'd0,  -1,        0,        0};
        vecs[5] = '{3'd7, 4'd15, 6,         2,        10};
        vecs[6] = '{3'd5, 4'd1,  0,         2,        0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i]);
        end

        // abort while byte 2 is presented, with ready high: abort wins
        @(negedge clk);
        base_addr = 3'd0; length = 4'd4; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_valid", 32'(out_valid), 32'd1);
        chk("abort_pre_data",  32'(out_data),  32'h50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_outputs("abort");
        begin
            int nd = 0;
            int nb = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done) nd++;
                if (busy) nb++;
            end
            chk("abort_no_done", nd, 0);
            chk("abort_stays_idle", nb, 0);
        end
        run_xfer('{3'd2, 4'd2, -1, 0, 0});

        // abort and start together in IDLE: nothing starts
        @(negedge clk);
        base_addr = 3'd1; length = 4'd3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_idle_outputs("abort_start");
        @(negedge clk);
        chk("abort_start_later_busy", 32'(busy), 32'd0);

        // reset while in CAPT, with start held high
        @(negedge clk);
        base_addr = 3'd3; length = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("capt_busy", 32'(busy), 32'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk_idle_outputs("rst_capt");
        chk("rst_capt_out_data", 32'(out_data), 32'd0);
        chk("rst_capt_mem_addr", 32'(mem_addr), 32'd0);
        run_xfer('{3'd1, 4'd2, -1, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
